// File: rtl/tone_key_arbiter.sv
// Shares one square-wave tone divider among NKEYS key switches and drives a speaker pin.
// A new note is taken only at a full-period boundary, so no runt pulse is emitted.
module tone_key_arbiter #(
  parameter int unsigned M     = 20,
  parameter int unsigned NKEYS = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NKEYS-1:0] keys,
  output logic             speaker,
  output logic             active,
  output logic [2:0]       note_idx
);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e             state_q, state_d;
  logic [NKEYS-1:0]   sync_q, keys_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         winner;
  logic               any_key;
  logic [CNT_W-1:0]   tc;

  // Half-period terminal counts, C4..C5; every branch folds to a constant.
  function automatic logic [CNT_W-1:0] term_count(input logic [2:0] k);
    logic [CNT_W-1:0] r;
    unique case (k)
      3'd0: r = CNT_W'(M * 1911 - 1);
      3'd1: r = CNT_W'(M * 1703 - 1);
      3'd2: r = CNT_W'(M * 1517 - 1);
      3'd3: r = CNT_W'(M * 1432 - 1);
      3'd4: r = CNT_W'(M * 1276 - 1);
      3'd5: r = CNT_W'(M * 1136 - 1);
      3'd6: r = CNT_W'(M * 1012 - 1);
      3'd7: r = CNT_W'(M * 956 - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Lowest-index key wins: scan downward so the last hit is the lowest set bit.
  always_comb begin
    winner = 3'd0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (keys_s[i]) winner = 3'(i);
    end
  end

  assign any_key = |keys_s;
  assign tc      = term_count(sel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (enable && any_key) begin
          sel_d   = winner;
          phase_d = 1'b1;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (!enable) begin
          state_d = StIdle;
          phase_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != tc) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
          end else if (any_key) begin
            // Full period done: re-arbitrate among keys held now.
            sel_d   = winner;
            phase_d = 1'b1;
          end else begin
            state_d = StIdle;
            phase_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      keys_s  <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      sync_q  <= keys;
      keys_s  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
    end
  end

  assign speaker  = phase_q;
  assign active   = (state_q == StPlay);
  assign note_idx = sel_q;

endmodule

// File: tb/tb_tone_key_arbiter.sv
// Randomised bench for tone_key_arbiter: a timestamp-based tone model predicts every output
// change; monitors pop those predictions whenever the DUT outputs change.
module tb_tone_key_arbiter;

  localparam int HP [8] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

  typedef struct packed {
    logic [7:0] h1;
    logic [7:0] h2;
    logic       playing;
    logic [2:0] note;
    int         ps;
    logic       spk;
    logic       act;
  } mstate_t;

  typedef struct packed {
    int         cyc;
    logic       spk;
    logic       act;
    logic [2:0] note;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] keys = 8'h00;
  logic       speaker, active;
  logic [2:0] note_idx;

  logic       rst_big = 1'b1;
  logic       enable_big = 1'b1;
  logic [7:0] keys_big = 8'h01;
  logic       speaker_big, active_big;
  logic [2:0] note_big;

  int      cyc = 0;
  int      compared = 0;
  int      failed = 0;
  bit      running = 1'b1;
  ev_t     q_s[$];
  ev_t     q_b[$];
  mstate_t ms_s = '0;
  mstate_t ms_b = '0;
  mstate_t nx;
  ev_t     ev;
  logic [4:0] prev_s = '0;
  logic [4:0] prev_b = '0;

  tone_key_arbiter #(.M(1), .NKEYS(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .keys(keys),
    .speaker(speaker), .active(active), .note_idx(note_idx)
  );

  tone_key_arbiter #(.M(20), .NKEYS(8), .CNT_W(16)) u_big (
    .clk(clk), .rst(rst_big), .enable(enable_big), .keys(keys_big),
    .speaker(speaker_big), .active(active_big), .note_idx(note_big)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // A tone is a period start time plus a half length; outputs follow from elapsed cycles.
  function automatic mstate_t model_step(input mstate_t s, input logic r, input logic e,
                                         input logic [7:0] k, input int m, input int c);
    mstate_t n = s;
    logic [7:0] ks;
    int half;
    if (r) begin
      n = '0;
      return n;
    end
    ks   = s.h2;
    n.h2 = s.h1;
    n.h1 = k;
    if (!s.playing) begin
      if (e && ks != 8'h00) begin
        n.playing = 1'b1; n.note = lowest(ks); n.ps = c; n.spk = 1'b1; n.act = 1'b1;
      end
    end else if (!e) begin
      n.playing = 1'b0; n.spk = 1'b0; n.act = 1'b0;
    end else begin
      half = m * HP[s.note];
      if (c - s.ps == half) begin
        n.spk = 1'b0;
      end else if (c - s.ps == 2 * half) begin
        if (ks != 8'h00) begin
          n.note = lowest(ks); n.ps = c; n.spk = 1'b1;
        end else begin
          n.playing = 1'b0; n.act = 1'b0; n.spk = 1'b0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    nx = model_step(ms_s, rst, enable, keys, 1, cyc);
    if ({nx.spk, nx.act, nx.note} != {ms_s.spk, ms_s.act, ms_s.note}) begin
      ev.cyc = cyc; ev.spk = nx.spk; ev.act = nx.act; ev.note = nx.note;
      q_s.push_back(ev);
    end
    ms_s = nx;
    nx = model_step(ms_b, rst_big, enable_big, keys_big, 20, cyc);
    if ({nx.spk, nx.act, nx.note} != {ms_b.spk, ms_b.act, ms_b.note}) begin
      ev.cyc = cyc; ev.spk = nx.spk; ev.act = nx.act; ev.note = nx.note;
      q_b.push_back(ev);
    end
    ms_b = nx;
  end

  task automatic check_ev(input string nm, input ev_t e, input logic s, input logic a,
                          input logic [2:0] n);
    compared++;
    if (e.cyc != cyc || e.spk !== s || e.act !== a || e.note !== n) begin
      failed++;
      $display("FAIL %s_event: got cycle %0d spk=%0b act=%0b note=%0d, want cycle %0d spk=%0b act=%0b note=%0d",
               nm, cyc, s, a, n, e.cyc, e.spk, e.act, e.note);
    end
  endtask

  task automatic report_missing(input string nm, input ev_t e);
    compared++;
    failed++;
    $display("FAIL %s_missing: outputs unchanged at cycle %0d, want spk=%0b act=%0b note=%0d",
             nm, e.cyc, e.spk, e.act, e.note);
  endtask

  task automatic report_extra(input string nm, input logic [4:0] cur);
    compared++;
    failed++;
    $display("FAIL %s_unexpected: cycle %0d got spk/act/note=%b, want no change", nm, cyc, cur);
  endtask

  always @(negedge clk) begin
    if (running) begin
      while (q_s.size() > 0 && q_s[0].cyc < cyc) report_missing("small", q_s.pop_front());
      if ({speaker, active, note_idx} != prev_s) begin
        if (q_s.size() == 0) report_extra("small", {speaker, active, note_idx});
        else check_ev("small", q_s.pop_front(), speaker, active, note_idx);
        prev_s = {speaker, active, note_idx};
      end
    end
  end

  always @(negedge clk) begin
    if (running) begin
      while (q_b.size() > 0 && q_b[0].cyc < cyc) report_missing("big", q_b.pop_front());
      if ({speaker_big, active_big, note_big} != prev_b) begin
        if (q_b.size() == 0) report_extra("big", {speaker_big, active_big, note_big});
        else check_ev("big", q_b.pop_front(), speaker_big, active_big, note_big);
        prev_b = {speaker_big, active_big, note_big};
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic check_zero(input string nm);
    compared++;
    if (speaker !== 1'b0 || active !== 1'b0 || note_idx !== 3'd0) begin
      failed++;
      $display("FAIL %s: got spk=%0b act=%0b note=%0d, want all 0", nm, speaker, active, note_idx);
    end
  endtask

  int act_sel;

  initial begin
    @(negedge clk);
    #1;
    check_zero("reset_state");
    #1;
    rst = 1'b0;
    rst_big = 1'b0;
    // Single key 5, then key 2 pressed part-way into a high half.
    enable = 1'b1;
    keys = 8'h20;
    wait_n(2 * 2272 + 600);
    keys = 8'h24;
    wait_n(3 * 3034);
    keys = 8'h00;
    wait_n(3000);
    // Key 7 released around count 100 of its high half.
    keys = 8'h80;
    wait_n(103);
    keys = 8'h00;
    wait_n(2500);
    // Disable during the high half, then re-enable with the key held.
    keys = 8'h20;
    wait_n(500);
    enable = 1'b0;
    wait_n(20);
    enable = 1'b1;
    wait_n(3000);
    // Asynchronous reset mid-note.
    wait_n(300);
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    wait_n(3);
    rst = 1'b0;
    wait_n(3000);
    while (cyc < 68000) begin
      act_sel = $urandom_range(0, 9);
      if (act_sel <= 5) keys = 8'($urandom) & 8'($urandom) & 8'($urandom);
      else if (act_sel == 6) enable = ($urandom_range(0, 3) != 0);
      else if (act_sel == 7) begin
        rst = 1'b1;
        wait_n($urandom_range(1, 3));
        rst = 1'b0;
      end else keys = 8'h00;
      wait_n($urandom_range(1, 2500));
    end
    keys = 8'h00;
    enable = 1'b1;
    while (cyc < 76500) @(negedge clk);
    @(negedge clk);
    #1;
    running = 1'b0;
    compared++;
    if (q_s.size() != 0 || q_b.size() != 0) begin
      failed++;
      $display("FAIL pending_events: got %0d small / %0d big left, want 0 / 0",
               q_s.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/tone_key_arbiter.md
Name: tone_key_arbiter

Overview:
- Shares one square-wave tone generator among NKEYS key switches (C4..C5 scale) and drives a single speaker pin.
- Synchronises the keys, picks one winner by fixed priority and sequences the divider.
- Changes the note only at full-period boundaries, so the speaker never emits a runt pulse.
- Sits between the board switches and the speaker pin.

Parameters:
- M, 20, system clock in MHz; divider terminal count = M*HP[k].
- NKEYS, 8, number of key inputs (fixed at 8 for the note table).
- CNT_W, 16, divider counter width; must hold M*1911-1 (38219 at M=20).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  master sound enable; low forces IDLE.
- keys  in  NKEYS  raw key switches, bit k requests note k, asynchronous to clk.
- speaker  out  1  registered square-wave output.
- active  out  1  high while in PLAY.
- note_idx  out  3  index of the note currently sounding; held at last value in IDLE.

Behaviour:
- Note table HP[k], half-period in us: 0 = 1911 (C4), 1 = 1703, 2 = 1517, 3 = 1432, 4 = 1276, 5 = 1136 (A4), 6 = 1012, 7 = 956 (C5).
- Terminal count TC[k] = M*HP[k]-1. The division is constant and computed at elaboration.
- Reset (async, any time including mid-note): sync flops = 0, state = IDLE, cnt = 0, phase = 0, sel = 0.
  - Outputs during reset: speaker = 0, active = 0, note_idx = 0.
- Synchroniser:
  - keys pass through 2 flops to give keys_s.
  - A key change is visible in keys_s 2 edges after it is sampled.
- Winner: lowest-index set bit of keys_s. any_key = OR of keys_s.
- State IDLE:
  - speaker = 0, cnt = 0.
  - If enable & any_key: sel <= winner, phase <= 1, cnt <= 0, go to PLAY.
  - Speaker is therefore high on the edge after keys_s shows the key.
- State PLAY, enable high:
  - If cnt != TC[sel]: cnt <= cnt+1.
  - If cnt == TC[sel]: cnt <= 0 and one of the following.
    - phase = 1 (end of high half): phase <= 0.
    - phase = 0 (end of full period): re-arbitrate.
      - If any_key: sel <= winner, phase <= 1, stay in PLAY.
      - Otherwise: go to IDLE with phase = 0.
- State PLAY, enable low: next edge go to IDLE, phase <= 0, cnt <= 0. Speaker drops immediately; runt pulse allowed only on disable.
- Key changes mid-period are ignored until the full-period boundary. Key release mid-period still finishes the current period.
- Simultaneous keys: lowest index wins. Pressing a lower key while a higher one plays switches at the next boundary.
- Output mapping: speaker = phase, active = (state == PLAY), note_idx = sel.
- Period: every emitted period is exactly 2*(TC[sel]+1) clocks, high half first.
- Counter: never exceeds TC[sel]. cnt is unsigned CNT_W bits; no wrap beyond TC.

Test Plan:
- Reset: rst pulsed mid-note (M=1, key 5 held) -> speaker, active, note_idx go to 0 asynchronously; after release, tone restarts from phase 1 with cnt 0.
- Single key: M=1, keys=8'b0010_0000 -> speaker high 3 edges after the key (2 sync, 1 IDLE->PLAY); 1136 clocks high, 1136 low, repeating; note_idx = 5; active = 1.
- Priority and boundary: key 5 playing, key 2 pressed mid-high-half -> finishes the 1136/1136 period, then note_idx = 2 with 1517/1517 periods; no pulse shorter than 1136.
- Release: M=1, key 7 released at cnt = 100 of the high half -> remaining high half plus 956 low clocks complete, then IDLE, active = 0, speaker = 0, note_idx stays 7.
- Disable: enable dropped during the high half -> one edge later speaker = 0 and state IDLE; re-asserting with key held restarts the note from phase 1.
- Extremes: M=20, key 0 held -> period exactly 76440 clocks (2*38220); cnt never exceeds 38219; no overflow.
